// File: rtl/psram_pkg.sv
// Shared states and command codes for the QPI PSRAM device model.
package psram_pkg;

    typedef enum logic [2:0] {
        CMD,
        ADDR,
        WAIT,
        RDATA,
        WDATA,
        DONE,
        ERR
    } psram_state_t;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QPI_EX = 8'hF5;

    localparam int ADDR_NIBBLES = 6;

endpackage

// File: rtl/psram_mem.sv
// Byte-wide PSRAM array: asynchronous read, write on posedge sck. No reset.
module psram_mem #(
    parameter int ADDR_BITS = 22
) (
    input  logic                 sck,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge sck) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/psram_qpi_model.sv
// QPI PSRAM device model: SPI/QPI command phase, quad address/data, wrapping
// bursts, sticky unsupported-command flag and a magic-write trap pulse.
module psram_qpi_model
    import psram_pkg::*;
#(
    parameter int          ADDR_BITS   = 22,
    parameter int          WAIT_CYCLES = 6,
    parameter bit          QPI_RESET   = 1'b0,
    parameter int unsigned TRAP_ADDR   = 0,
    parameter logic [7:0]  TRAP_DATA   = 8'hAA
) (
    input  logic       sck,
    input  logic       rst_n,
    input  logic       ce_n,
    input  logic [3:0] dio_in,
    output logic [3:0] dio_out,
    output logic       dio_oe,
    output logic       qpi_mode,
    output logic       err,
    output logic       trap
);

    psram_state_t         state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [7:0]           cmd_sr, cmd_nxt, cmd_shift;
    logic [3:0]           cmd_last;
    logic [ADDR_BITS-1:0] addr, addr_nxt;
    logic                 is_wr, is_wr_nxt;
    logic                 nib_lo, nib_lo_nxt;
    logic [3:0]           hold_hi, hold_hi_nxt;
    logic                 set_qpi, clr_qpi, set_err;
    logic                 mem_we;
    logic [7:0]           mem_wdata, mem_rdata;
    logic                 txn_rst_n;

    // Transaction state is wiped by either reset or a deselect; mode/err survive ce_n.
    assign txn_rst_n = rst_n & ~ce_n;

    assign cmd_shift = qpi_mode ? {cmd_sr[3:0], dio_in} : {cmd_sr[6:0], dio_in[0]};
    assign cmd_last  = qpi_mode ? 4'd1 : 4'd7;
    assign mem_wdata = {hold_hi, dio_in};

    always_ff @(posedge sck or negedge txn_rst_n) begin
        if (!txn_rst_n) begin
            state   <= CMD;
            cnt     <= '0;
            cmd_sr  <= '0;
            addr    <= '0;
            is_wr   <= 1'b0;
            nib_lo  <= 1'b0;
            hold_hi <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cmd_sr  <= cmd_nxt;
            addr    <= addr_nxt;
            is_wr   <= is_wr_nxt;
            nib_lo  <= nib_lo_nxt;
            hold_hi <= hold_hi_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        cmd_nxt     = cmd_sr;
        addr_nxt    = addr;
        is_wr_nxt   = is_wr;
        nib_lo_nxt  = nib_lo;
        hold_hi_nxt = hold_hi;
        set_qpi     = 1'b0;
        clr_qpi     = 1'b0;
        set_err     = 1'b0;
        mem_we      = 1'b0;
        case (state)
            CMD: begin
                cmd_nxt = cmd_shift;
                cnt_nxt = cnt + 4'd1;
                if (cnt == cmd_last) begin
                    cnt_nxt = '0;
                    case (cmd_shift)
                        CMD_QREAD:  begin state_nxt = ADDR; is_wr_nxt = 1'b0; end
                        CMD_QWRITE: begin state_nxt = ADDR; is_wr_nxt = 1'b1; end
                        CMD_QPI_EN: begin state_nxt = DONE; set_qpi = 1'b1; end
                        CMD_QPI_EX: begin state_nxt = DONE; clr_qpi = 1'b1; end
                        default:    begin state_nxt = ERR;  set_err = 1'b1; end
                    endcase
                end
            end
            ADDR: begin
                // Only the low ADDR_BITS of the 24-bit address survive the shift.
                addr_nxt = ADDR_BITS'({addr, dio_in});
                cnt_nxt  = cnt + 4'd1;
                if (cnt == 4'(ADDR_NIBBLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = is_wr ? WDATA : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'(WAIT_CYCLES - 1)) begin
                    cnt_nxt    = '0;
                    nib_lo_nxt = 1'b0;
                    state_nxt  = RDATA;
                end
            end
            RDATA: begin
                nib_lo_nxt = ~nib_lo;
                if (nib_lo) addr_nxt = addr + ADDR_BITS'(1);
            end
            WDATA: begin
                nib_lo_nxt = ~nib_lo;
                if (nib_lo) begin
                    mem_we   = 1'b1;
                    addr_nxt = addr + ADDR_BITS'(1);
                end else begin
                    hold_hi_nxt = dio_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            qpi_mode <= QPI_RESET;
            err      <= 1'b0;
            trap     <= 1'b0;
        end else begin
            if (!ce_n && set_qpi) qpi_mode <= 1'b1;
            if (!ce_n && clr_qpi) qpi_mode <= 1'b0;
            if (!ce_n && set_err) err      <= 1'b1;
            trap <= !ce_n && mem_we && (addr == ADDR_BITS'(TRAP_ADDR)) && (mem_wdata == TRAP_DATA);
        end
    end

    psram_mem #(.ADDR_BITS(ADDR_BITS)) u_mem (
        .sck   (sck),
        .we    (mem_we),
        .addr  (addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign dio_oe  = (state == RDATA);
    assign dio_out = dio_oe ? (nib_lo ? mem_rdata[3:0] : mem_rdata[7:4]) : 4'h0;

endmodule

// File: tb/tb_psram_qpi_model.sv
// Scoreboard bench for psram_qpi_model: expected read nibbles queued from a byte model.
module tb_psram_qpi_model;
    import psram_pkg::*;

    localparam int ABITS = 22;
    localparam int WCYC  = 6;
    localparam int unsigned AMASK = (1 << ABITS) - 1;

    logic       sck = 1'b0;
    logic       rst_n = 1'b0;
    logic       ce_n = 1'b1;
    logic [3:0] dio_in = 4'h0;
    logic [3:0] dio_out;
    logic       dio_oe, qpi_mode, err, trap;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] model [int unsigned];
    logic [3:0] exp_q [$];

    psram_qpi_model #(
        .ADDR_BITS(ABITS), .WAIT_CYCLES(WCYC), .QPI_RESET(1'b0),
        .TRAP_ADDR(0), .TRAP_DATA(8'hAA)
    ) dut (
        .sck(sck), .rst_n(rst_n), .ce_n(ce_n), .dio_in(dio_in),
        .dio_out(dio_out), .dio_oe(dio_oe), .qpi_mode(qpi_mode),
        .err(err), .trap(trap)
    );

    always #5 sck = ~sck;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c, input bit q);
        ce_n = 1'b0;
        if (q) begin
            dio_in = c[7:4]; tick();
            dio_in = c[3:0]; tick();
        end else begin
            for (int i = 7; i >= 0; i--) begin
                dio_in = {3'b000, c[i]};
                tick();
            end
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) begin
            dio_in = a[i*4 +: 4];
            tick();
        end
    endtask

    task automatic end_txn();
        ce_n = 1'b1;
        #1;
        chk("oe_off", dio_oe, 0);
        tick();
        chk("trap_clr", trap, 0);
    endtask

    task automatic do_write(input bit q, input logic [23:0] a, input logic [7:0] b[$]);
        int unsigned p = a & AMASK;
        send_cmd(CMD_QWRITE, q);
        send_addr(a);
        foreach (b[i]) begin
            dio_in = b[i][7:4]; tick();
            dio_in = b[i][3:0]; tick();
            model[p] = b[i];
            chk("trap", trap, (p == 0 && b[i] == 8'hAA));
            p = (p + 1) & AMASK;
        end
        end_txn();
    endtask

    task automatic do_read(input bit q, input logic [23:0] a, input int n);
        int unsigned p = a & AMASK;
        logic [7:0] bt;
        for (int i = 0; i < n; i++) begin
            bt = model[p];
            exp_q.push_back(bt[7:4]);
            exp_q.push_back(bt[3:0]);
            p = (p + 1) & AMASK;
        end
        send_cmd(CMD_QREAD, q);
        send_addr(a);
        for (int i = 0; i < WCYC; i++) begin
            tick();
            chk("wait_oe", dio_oe, (i == WCYC - 1));
        end
        for (int k = 0; k < 2 * n; k++) begin
            if (k > 0) tick();
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else chk("rd_nib", dio_out, exp_q.pop_front());
        end
        end_txn();
    endtask

    task automatic mode_cmd(input logic [7:0] c, input bit q);
        send_cmd(c, q);
        end_txn();
    endtask

    initial begin
        #2;
        chk("rst_oe", dio_oe, 0);
        chk("rst_out", dio_out, 0);
        chk("rst_qpi", qpi_mode, 0);
        chk("rst_err", err, 0);
        chk("rst_trap", trap, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // SPI write then read
        do_write(1'b0, 24'h000010, '{8'h12, 8'h34});
        chk("spi_qpi", qpi_mode, 0);
        chk("spi_err", err, 0);
        do_read(1'b0, 24'h000010, 2);

        // enter QPI, wrapping round-trip
        mode_cmd(CMD_QPI_EN, 1'b0);
        chk("qpi_on", qpi_mode, 1);
        do_write(1'b1, 24'h3FFFFE, '{8'hDE, 8'hAD, 8'hBE, 8'hEF});
        do_read(1'b1, 24'h3FFFFE, 4);
        do_read(1'b1, 24'h000000, 2);
        do_read(1'b1, 24'hC00001, 1);
        mode_cmd(CMD_QPI_EX, 1'b1);
        chk("qpi_off", qpi_mode, 0);

        // unsupported command
        send_cmd(8'hA5, 1'b0);
        chk("err_set", err, 1);
        for (int i = 0; i < 6; i++) begin
            dio_in = 4'($urandom_range(0, 15));
            tick();
            chk("err_oe", dio_oe, 0);
        end
        end_txn();
        do_read(1'b0, 24'h000010, 2);
        chk("err_sticky", err, 1);

        // trap
        do_write(1'b0, 24'h000000, '{8'hAA});
        do_write(1'b0, 24'h000000, '{8'h55});
        do_read(1'b0, 24'h000000, 2);

        // lone high nibble is dropped
        send_cmd(CMD_QWRITE, 1'b0);
        send_addr(24'h000010);
        dio_in = 4'h9;
        tick();
        end_txn();
        do_read(1'b0, 24'h000010, 1);

        // reset mid-read
        mode_cmd(CMD_QPI_EN, 1'b0);
        chk("qpi_on2", qpi_mode, 1);
        send_cmd(CMD_QREAD, 1'b1);
        send_addr(24'h000010);
        for (int i = 0; i < WCYC; i++) tick();
        chk("mid_oe", dio_oe, 1);
        chk("mid_nib", dio_out, 4'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", dio_oe, 0);
        chk("rst_mid_qpi", qpi_mode, 0);
        chk("rst_mid_err", err, 0);
        ce_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(1'b0, 24'h000010, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/psram_qpi_model.md
Name: psram_qpi_model

Overview:
- Parametrised successor to the fixed 1-4-4 PSRAM device model used behind the SoC PSRAM controller.
- Adds SPI/QPI mode switching (35h/F5h) and configurable depth and read latency.
- Supports unbounded bursts with address wrap, and reports unsupported commands through a sticky error flag instead of halting.
- Uses split I/O pins; the SoC top-level wrapper builds the inout from dio_out/dio_oe.

Parameters:
ADDR_BITS, 22, byte-address width; memory holds 2**ADDR_BITS bytes; address bits above ADDR_BITS-1 are ignored.
WAIT_CYCLES, 6, dummy sck cycles between the last address nibble and the first read nibble (legal range 1-15).
QPI_RESET, 0, mode after rst_n: 0 = SPI command phase, 1 = QPI.
TRAP_ADDR, 0, byte address that is watched for the magic write.
TRAP_DATA, 8'hAA, magic byte value.

Ports:
sck  input  1  device clock; all sampling on posedge.
rst_n  input  1  asynchronous, active-low reset.
ce_n  input  1  chip enable, active-low; high asynchronously aborts or ends a transaction.
dio_in  input  4  data pins sampled from the master.
dio_out  output  4  data pins driven to the master.
dio_oe  output  1  output enable for dio_out.
qpi_mode  output  1  current mode: 1 = QPI.
err  output  1  sticky unsupported-command flag.
trap  output  1  one-sck-cycle pulse on the magic write.

Behaviour:
- Reset (rst_n=0): state=CMD, cnt=0, qpi_mode=QPI_RESET, err=0, trap=0, dio_oe=0, dio_out=0. Memory contents are not affected. rst_n dominates every other input.
- ce_n=1 (asynchronous): state=CMD, cnt=0, cmd/addr/partial nibble cleared, dio_oe=0. qpi_mode and err are retained.
- States: CMD, ADDR, WAIT, RDATA, WDATA, DONE, ERR.
- CMD:
  - SPI: 8 posedges, dio_in[0] shifted in MSB first.
  - QPI: 2 posedges, nibbles high first.
  - On the final command posedge, decode:
    - EBh -> ADDR (read).
    - 38h -> ADDR (write).
    - 35h -> qpi_mode=1 -> DONE.
    - F5h -> qpi_mode=0 -> DONE.
    - Any other value -> err=1 -> ERR.
  - A mode change applies from the next transaction.
- ADDR: 6 posedges, one nibble each, MSB first (24 bits). Then:
  - read -> WAIT;
  - write -> WDATA.
- WAIT:
  - WAIT_CYCLES posedges with dio_oe=0.
  - On the final wait posedge: dio_oe=1 and dio_out = high nibble of mem[addr]; state=RDATA.
- RDATA:
  - Each posedge advances one nibble: high then low nibble of each byte.
  - After a low nibble, addr = (addr+1) mod 2**ADDR_BITS and the next byte's high nibble is presented.
  - Read data is combinational from the current addr; stays in RDATA until ce_n rises.
- WDATA:
  - Nibbles arrive high first.
  - On the posedge of each low nibble, mem[addr] = {held high nibble, dio_in}, then addr increments with wrap.
  - A lone high nibble at ce_n rise is discarded.
- Trap: trap=1 for exactly the cycle after a write of TRAP_DATA to TRAP_ADDR; otherwise trap=0.
- DONE, ERR: ignore sck until ce_n rises; dio_oe=0.
- Write then read of the same address in separate transactions returns the written data. No read-during-write hazard exists because each transaction is one direction only.
- Bursts have no length limit; wrap at the top of memory is modular.

Decomposition:
- psram_pkg:
  - state enum psram_state_t (CMD, ADDR, WAIT, RDATA, WDATA, DONE, ERR);
  - command constants CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_QPI_EN=8'h35, CMD_QPI_EX=8'hF5;
  - ADDR_NIBBLES=6.
- Sub-module psram_mem:
  - 2**ADDR_BITS x 8 array;
  - asynchronous read port;
  - write port synchronous to posedge sck.
- Top module holds the FSM, counters, shift registers, mode/err/trap logic.

Test Plan:
- SPI write 38h, address 000010h, nibbles 1,2,3,4 -> mem[10h]=12h, mem[11h]=34h; qpi_mode=0; err=0.
- SPI read EBh, address 000010h, WAIT_CYCLES=6 -> dio_oe rises on the 6th wait posedge; sampled nibbles 1,2,3,4; dio_oe=0 immediately after ce_n rises.
- 35h in SPI -> qpi_mode=1. Then QPI 38h/EBh (2-cycle command) round-trip of 0xDEADBEEF at 3FFFFEh with ADDR_BITS=22:
  - bytes land at 3FFFFEh, 3FFFFFh, 000000h, 000001h (wrap);
  - read back matches.
  - F5h -> qpi_mode=0.
- Command A5h -> err=1, no memory change, sck ignored until ce_n rises. The next valid read succeeds and err stays 1 until rst_n.
- Write AAh to address 000000h -> trap high for exactly 1 sck cycle. Write 55h there -> no trap.
- Abort cases:
  - ce_n rises after one data nibble of a write -> no byte written.
  - rst_n asserted mid-read -> dio_oe=0 at once; qpi_mode returns to QPI_RESET.
